deemph_iir: RTL and testbench
=============================

// Module: deemph_iir
// PURPOSE
//  First-order IIR de-emphasis filter (75 us, Fs = 32 kHz) for the demodulated FM audio stream.
//  Sits directly upstream of the volume gain stage: pops samples from the demod output FIFO,
//  filters them, pushes results into the FIFO feeding the gain stage. Fixed-point, 10-bit quant.
// PARAMETERS
//  DATA_WIDTH  32    sample width, signed two's complement
//  QUANT_BITS  10    coefficient fractional bits; dequantize = arithmetic >>> QUANT_BITS
//  B0          174   feed-forward tap x[n]   ((1-a)/2 * 2^10, a = 0.659)
//  B1          174   feed-forward tap x[n-1]
//  A1          675   feedback tap y[n-1]     (a * 2^10)
//  SAT_BITS    16    output clamp width (used only with DEEMPH_SAT_EN)
// PORTS
//  clock      in   1           system clock, all logic on rising edge
//  reset      in   1           synchronous, active-low reset
//  in_empty   in   1           upstream FIFO empty
//  in_dout    in   DATA_WIDTH  upstream FIFO head (first-word-fall-through)
//  in_rd_en   out  1           pop upstream FIFO
//  out_full   in   1           downstream FIFO full
//  out_wr_en  out  1           push downstream FIFO
//  out_din    out  DATA_WIDTH  filtered sample
// BEHAVIOUR
//  y[n] = (B0*x[n] + B1*x[n-1] + A1*y[n-1]) >>> QUANT_BITS, truncated to DATA_WIDTH.
//  Products 2*DATA_WIDTH signed; accumulator 2*DATA_WIDTH; one shared multiplier.
//  FSM: S_IDLE -> S_MAC0 -> S_MAC1 -> S_MAC2 -> S_WRITE -> S_IDLE.
//   S_IDLE : in_rd_en = !in_empty (comb.); on pop, x <= in_dout, go S_MAC0; else stay.
//   S_MAC0 : acc <= B0*x.   S_MAC1: acc <= acc + B1*x_prev.   S_MAC2: acc <= acc + A1*y_prev.
//   S_WRITE: y = acc >>> QUANT_BITS; out_wr_en = !out_full (comb.), out_din = y;
//            on push: x_prev <= x, y_prev <= y, go S_IDLE; while out_full: hold, no state update.
//  Latency pop->push 4 cycles min; throughput 1 sample / 5 cycles; never pops while busy.
//  in_rd_en and out_wr_en never high in same cycle. No sample dropped or duplicated under backpressure.
//  Reset (any state, incl. mid-MAC): state S_IDLE; x, x_prev, y_prev, acc = 0; in_rd_en = 0,
//   out_wr_en = 0, out_din = 0. In-flight sample discarded; filter history cleared.
//  out_din is held at last y (0 after reset) when out_wr_en is low.
// CONFIGURATION
//  DEEMPH_SAT_EN defined: out_din clamped to [-(2^(SAT_BITS-1)), 2^(SAT_BITS-1)-1], sign-extended
//   to DATA_WIDTH; y_prev stores the UNclamped y (filter state stays linear).
//  Undefined: out_din = truncated y, no clamp logic generated.
// STRUCTURE
//  fm_radio_pkg: DATA_WIDTH, QUANT_BITS constants; deemph coefficient localparams;
//   dequantize() function (64-bit signed in, >>> QUANT_BITS, 32-bit out); state enum typedef.
//  No sub-module: single FSM + shared multiplier; multiply kept inline via package function.
// TESTING
//  Impulse: x = 1024, 0, 0 -> out 174, 288, 189.
//  Backpressure: hold out_full=1 for 10 cycles in S_WRITE -> out_din stable, no pop, single push on release.
//  Empty input: in_empty=1 for 20 cycles -> in_rd_en/out_wr_en stay 0, history unchanged.
//  Reset mid-op: assert reset in S_MAC1 after x=1024 -> no push; next x=1024 -> out 174 (history cleared).
//  DEEMPH_SAT_EN: x = 1000000 -> out 32767; x = -1000000 (fresh reset) -> out -32768.
//  Negative/DC: x = -1024 constant -> outputs monotonically approach ~-1022, never positive.

Source files
------------

// File: rtl/fm_radio_pkg.sv
// fm_radio_pkg: shared FM-radio constants, de-emphasis coefficients, FSM state type and fixed-point helpers
package fm_radio_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int QUANT_BITS = 10;
  localparam int SAT_BITS = 16;
  localparam logic signed [DATA_WIDTH-1:0] DEEMPH_B0 = 174;
  localparam logic signed [DATA_WIDTH-1:0] DEEMPH_B1 = 174;
  localparam logic signed [DATA_WIDTH-1:0] DEEMPH_A1 = 675;
  typedef enum logic [2:0] {S_IDLE, S_MAC0, S_MAC1, S_MAC2, S_WRITE} deemph_state_t;
  function automatic logic signed [2*DATA_WIDTH-1:0] mac_mul(input logic signed [DATA_WIDTH-1:0] a,
                                                             input logic signed [DATA_WIDTH-1:0] b);
    return (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
  endfunction
  function automatic logic signed [DATA_WIDTH-1:0] dequantize(input logic signed [2*DATA_WIDTH-1:0] v);
    logic signed [2*DATA_WIDTH-1:0] s;
    s = v >>> QUANT_BITS;
    return s[DATA_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/deemph_iir.sv
// deemph_iir: first-order IIR de-emphasis filter between demod FIFO and gain-stage FIFO, one shared multiplier
// Ports: clock, reset (sync, active-low); in_empty/in_dout/in_rd_en pop the FWFT upstream FIFO;
//   out_full/out_wr_en/out_din push the downstream FIFO. Define DEEMPH_SAT_EN to clamp out_din to SAT_BITS.
module deemph_iir
  import fm_radio_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_empty,
  input  logic [DATA_WIDTH-1:0] in_dout,
  output logic                  in_rd_en,
  input  logic                  out_full,
  output logic                  out_wr_en,
  output logic [DATA_WIDTH-1:0] out_din
);
  deemph_state_t state;
  logic signed [DATA_WIDTH-1:0] x, x_prev, y_prev, out_q, coef, opnd, y, y_out;
  logic signed [2*DATA_WIDTH-1:0] acc, prod;
  always_comb begin
    coef = state == S_MAC0 ? DEEMPH_B0 : state == S_MAC1 ? DEEMPH_B1 : DEEMPH_A1;
    opnd = state == S_MAC0 ? x : state == S_MAC1 ? x_prev : y_prev;
    prod = mac_mul(coef, opnd);
    y = dequantize(acc);
  end
`ifdef DEEMPH_SAT_EN
  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'((1 << (SAT_BITS-1)) - 1);
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = DATA_WIDTH'(-(1 << (SAT_BITS-1)));
  assign y_out = y > SAT_MAX ? SAT_MAX : y < SAT_MIN ? SAT_MIN : y;
`else
  assign y_out = y;
`endif
  // handshakes are gated by reset so nothing moves while reset is held, whatever the state
  assign in_rd_en = reset && state == S_IDLE && !in_empty;
  assign out_wr_en = reset && state == S_WRITE && !out_full;
  assign out_din = out_wr_en ? y_out : out_q;
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_IDLE;
      x <= '0;
      x_prev <= '0;
      y_prev <= '0;
      acc <= '0;
      out_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (in_rd_en) begin
          x <= in_dout;
          state <= S_MAC0;
        end
        S_MAC0: begin
          acc <= prod;
          state <= S_MAC1;
        end
        S_MAC1: begin
          acc <= acc + prod;
          state <= S_MAC2;
        end
        S_MAC2: begin
          acc <= acc + prod;
          state <= S_WRITE;
        end
        S_WRITE: if (out_wr_en) begin
          x_prev <= x;
          y_prev <= y;
          out_q <= y_out;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_deemph_iir.sv
// tb_deemph_iir: directed scoreboard bench for deemph_iir
module tb_deemph_iir;
  logic clk, rst_n, in_empty, in_rd_en, out_full, out_wr_en;
  logic [31:0] in_dout, out_din;
  int checks = 0, errors = 0, cyc = 0, pops = 0, pushes = 0, pop_cyc = 0, p0, q0;
  logic signed [31:0] m_xp, m_yp, last_y, prev_y, v0;
  logic signed [31:0] exp_q[$];
  logic signed [31:0] pat[5] = '{3000, -2500, 12345, -77, 0};

  deemph_iir dut (
    .clock(clk), .reset(rst_n), .in_empty(in_empty), .in_dout(in_dout), .in_rd_en(in_rd_en),
    .out_full(out_full), .out_wr_en(out_wr_en), .out_din(out_din)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_rd_en) pops <= pops + 1;
    if (out_wr_en) pushes <= pushes + 1;
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) chk("rd_wr_excl", 64'(in_rd_en & out_wr_en), 64'(0));

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic model(input logic signed [31:0] xn, output logic signed [31:0] yo);
    longint acc, yfull;
    acc = 174 * longint'(xn) + 174 * longint'(m_xp) + 675 * longint'(m_yp);
    yfull = acc >>> 10;
    m_xp = xn;
    m_yp = yfull[31:0];
`ifdef DEEMPH_SAT_EN
    yo = (m_yp > 32767) ? 32767 : (m_yp < -32768) ? -32768 : m_yp;
`else
    yo = m_yp;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    in_empty = 0;
    in_dout = 32'd7;
    out_full = 0;
    repeat (2) @(negedge clk);
    chk("rst_rd_en", 64'(in_rd_en), 64'(0));
    chk("rst_wr_en", 64'(out_wr_en), 64'(0));
    chk("rst_out_din", 64'($signed(out_din)), 64'(0));
    in_empty = 1;
    rst_n = 1;
    m_xp = 0;
    m_yp = 0;
    exp_q.delete();
  endtask

  task automatic send(input logic signed [31:0] v, input bit keep);
    int n = 0;
    logic signed [31:0] e;
    @(negedge clk);
    in_dout = v;
    in_empty = 0;
    #1;
    while (!in_rd_en && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("pop_timeout", 64'(in_rd_en), 64'(1));
    if (in_rd_en) begin
      model(v, e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      pop_cyc = cyc;
      in_empty = !keep;
    end
  endtask

  task automatic recv(input string tag, input bit lat);
    int n = 0;
    logic signed [31:0] e;
    #1;
    while (!out_wr_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 64'(out_wr_en), 64'(1));
    if (out_wr_en) begin
      e = exp_q.size() > 0 ? exp_q.pop_front() : 32'sd0;
      chk(tag, 64'($signed(out_din)), 64'(e));
      last_y = out_din;
      @(posedge clk);
      #1;
      if (lat) chk({tag, "_lat"}, 64'(cyc - pop_cyc), 64'(4));
      chk({tag, "_held"}, 64'($signed(out_din)), 64'(last_y));
    end
  endtask

  initial begin
    rst_n = 0;
    in_empty = 1;
    in_dout = 0;
    out_full = 0;
    do_reset();
    send(1024, 0); recv("imp0", 1); chk("imp0_val", 64'(last_y), 64'(174));
    send(0, 0);    recv("imp1", 1); chk("imp1_val", 64'(last_y), 64'(288));
    send(0, 0);    recv("imp2", 1); chk("imp2_val", 64'(last_y), 64'(189));
    foreach (pat[i]) begin
      send(pat[i], 0);
      recv("pattern", 0);
    end
    in_empty = 1;
    repeat (20) begin
      @(negedge clk);
      chk("empty_rd_en", 64'(in_rd_en), 64'(0));
      chk("empty_wr_en", 64'(out_wr_en), 64'(0));
    end
    send(256, 0); recv("after_empty", 0);
    out_full = 1;
    send(500, 1);
    repeat (4) @(negedge clk);
    p0 = pops;
    q0 = pushes;
    v0 = out_din;
    repeat (10) begin
      @(negedge clk);
      chk("bp_wr_en", 64'(out_wr_en), 64'(0));
      chk("bp_rd_en", 64'(in_rd_en), 64'(0));
      chk("bp_hold", 64'($signed(out_din)), 64'(v0));
    end
    chk("bp_no_pop", 64'(pops), 64'(p0));
    out_full = 0;
    recv("bp_release", 0);
    chk("bp_one_push", 64'(pushes), 64'(q0 + 1));
    send(500, 0); recv("bp_next", 0);
    send(1024, 0);
    @(posedge clk);
    #1;
    q0 = pushes;
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    m_xp = 0;
    m_yp = 0;
    exp_q.delete();
    repeat (6) begin
      @(negedge clk);
      chk("rstmid_wr_en", 64'(out_wr_en), 64'(0));
    end
    chk("rstmid_no_push", 64'(pushes), 64'(q0));
    chk("rstmid_out_din", 64'($signed(out_din)), 64'(0));
    send(1024, 0); recv("rstmid_first", 0); chk("rstmid_val", 64'(last_y), 64'(174));
    do_reset();
    prev_y = 0;
    repeat (12) begin
      send(-1024, 0);
      recv("dc", 0);
      chk("dc_monotonic", 64'(last_y <= prev_y), 64'(1));
      chk("dc_nonpositive", 64'(last_y <= 0), 64'(1));
      prev_y = last_y;
    end
    do_reset();
    send(1000000, 0); recv("big_pos", 0);
`ifdef DEEMPH_SAT_EN
    chk("big_pos_val", 64'(last_y), 64'(32767));
`else
    chk("big_pos_val", 64'(last_y), 64'(169921));
`endif
    do_reset();
    send(-1000000, 0); recv("big_neg", 0);
`ifdef DEEMPH_SAT_EN
    chk("big_neg_val", 64'(last_y), -64'sd32768);
`else
    chk("big_neg_val", 64'(last_y), -64'sd169922);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
